// File: rtl/toggle_activity_monitor.sv
// Counts input/output toggles of an observed sub-circuit over fixed windows of accepted samples.
// Optional TOGGLE_ACTIVITY_ONES_EN adds rpt_ones, a per-window count of samples with out_bit=1.
module toggle_activity_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_vec,
  input  logic             out_bit,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_in_tog,
  output logic [CNT_W-1:0] rpt_out_tog,
`ifdef TOGGLE_ACTIVITY_ONES_EN
  output logic [CNT_W-1:0] rpt_ones,
`endif
  output logic             rpt_ovf
);

  localparam int unsigned SC_W = $clog2(WINDOW + 1);

  typedef enum logic {S_FIRST, S_ACCUM} state_e;

  state_e           state_q;
  logic [3:0]       prev_vec_q;
  logic             prev_out_q;
  logic [SC_W-1:0]  cnt_q;
  logic [CNT_W-1:0] in_acc_q, out_acc_q;
  logic             rpt_valid_q, rpt_ovf_q;
  logic [CNT_W-1:0] rpt_in_q, rpt_out_q;

  logic [3:0]       diff;
  logic [2:0]       pop;
  logic [CNT_W+2:0] in_sum;
  logic [CNT_W:0]   out_sum;
  logic [CNT_W-1:0] in_acc_d, out_acc_d;
  logic             out_tgl, win_close, xfer, rpt_load;

  assign diff    = in_vec ^ prev_vec_q;
  assign pop     = {2'b00, diff[0]} + {2'b00, diff[1]} + {2'b00, diff[2]} + {2'b00, diff[3]};
  assign out_tgl = out_bit ^ prev_out_q;

  // Sums carry spare high bits so saturation is a simple overflow test.
  assign in_sum    = {3'b000, in_acc_q} + {{CNT_W{1'b0}}, pop};
  assign in_acc_d  = (|in_sum[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : in_sum[CNT_W-1:0];
  assign out_sum   = {1'b0, out_acc_q} + {{CNT_W{1'b0}}, out_tgl};
  assign out_acc_d = out_sum[CNT_W] ? {CNT_W{1'b1}} : out_sum[CNT_W-1:0];

  assign win_close = in_valid && (state_q == S_ACCUM) && (cnt_q == SC_W'(WINDOW - 1));
  assign xfer      = rpt_valid_q && rpt_ready;
  assign rpt_load  = win_close && (!rpt_valid_q || xfer);

`ifdef TOGGLE_ACTIVITY_ONES_EN
  logic [CNT_W-1:0] ones_q, rpt_ones_q, ones_d;
  logic [CNT_W:0]   ones_sum;
  assign ones_sum = {1'b0, ones_q} + {{CNT_W{1'b0}}, out_bit};
  assign ones_d   = ones_sum[CNT_W] ? {CNT_W{1'b1}} : ones_sum[CNT_W-1:0];
  assign rpt_ones = rpt_ones_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q     <= '0;
      rpt_ones_q <= '0;
    end else begin
      if (in_valid) ones_q <= win_close ? '0 : ones_d;
      if (rpt_load) rpt_ones_q <= ones_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FIRST;
      prev_vec_q  <= '0;
      prev_out_q  <= 1'b0;
      cnt_q       <= '0;
      in_acc_q    <= '0;
      out_acc_q   <= '0;
      rpt_valid_q <= 1'b0;
      rpt_in_q    <= '0;
      rpt_out_q   <= '0;
      rpt_ovf_q   <= 1'b0;
    end else begin
      if (in_valid) begin
        prev_vec_q <= in_vec;
        prev_out_q <= out_bit;
        if (state_q == S_FIRST) begin
          state_q <= S_ACCUM;
          cnt_q   <= SC_W'(1);
        end else if (win_close) begin
          // prev is kept so the next window's first sample compares against this one.
          cnt_q     <= '0;
          in_acc_q  <= '0;
          out_acc_q <= '0;
        end else begin
          cnt_q     <= cnt_q + SC_W'(1);
          in_acc_q  <= in_acc_d;
          out_acc_q <= out_acc_d;
        end
      end

      if (rpt_load) begin
        rpt_valid_q <= 1'b1;
        rpt_in_q    <= in_acc_d;
        rpt_out_q   <= out_acc_d;
      end else if (win_close) begin
        rpt_ovf_q <= 1'b1;
      end else if (xfer) begin
        rpt_valid_q <= 1'b0;
      end
    end
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_in_tog  = rpt_in_q;
  assign rpt_out_tog = rpt_out_q;
  assign rpt_ovf     = rpt_ovf_q;

endmodule
